hazard_forward_unit: RTL and testbench

Parametrised forwarding and hazard controller for the 5-stage pipeline. It tracks the destination of every in-flight instruction in its own EX/MEM/WB shadow registers, so the datapath only has to present the ID-stage instruction. From that state it drives per-operand bypass selects for EX, inserts one-cycle load-use stalls, honours branch flush and data-memory wait, and keeps a saturating load-use stall counter.

---
 rtl/hazard_forward_unit_pkg.sv | 8 +
 rtl/hazard_fwd_match.sv | 38 +++
 rtl/hazard_forward_unit.sv | 126 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared bypass-select encodings for the hazard unit and the EX bypass muxes.
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/hazard_fwd_match.sv
// Bypass select for one EX operand from the MEM and WB producer fields.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// A load still in MEM has no data yet, so it never wins; MEM beats WB otherwise.
module hazard_fwd_match
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             used_i,
    input  logic             mem_valid_i,
    input  logic             mem_wb_en_i,
    input  logic             mem_is_load_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             wb_valid_i,
    input  logic             wb_wb_en_i,
    input  logic [REG_W-1:0] wb_dest_i,
    output logic [1:0]       sel_o
);

    logic reads_reg;
    logic mem_hit;
    logic wb_hit;

    assign reads_reg = used_i && (src_i != '0);
    assign mem_hit   = reads_reg && mem_valid_i && mem_wb_en_i && (mem_dest_i == src_i);
    assign wb_hit    = reads_reg && wb_valid_i && wb_wb_en_i && (wb_dest_i == src_i);

    always_comb begin
        sel_o = FWD_RF;
        if (mem_hit && !mem_is_load_i) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding/hazard controller: shadows EX/MEM/WB destinations, drives bypass selects and load-use stalls.
// Latency: outputs combinational from records + ID inputs; records advance on each posedge.
// Backpressure: mem_busy freezes every record and the counter; a load-use hit holds IF/ID one cycle.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_used,
    input  logic [REG_W-1:0]         id_dest,
    input  logic                     id_wb_en,
    input  logic                     id_is_load,
    input  logic                     flush,
    input  logic                     mem_busy,
    output logic [NUM_SRC*2-1:0]     fwd_sel,
    output logic                     stall_if_id,
    output logic                     bubble_ex,
    output logic                     freeze,
    output logic [CNT_W-1:0]         lu_stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             is_load;
        logic [REG_W-1:0] dest;
    } prod_t;

    // Past MEM only the bypass-relevant fields are kept; sources matter only while in EX.
    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic [REG_W-1:0] dest;
    } wb_rec_t;

    prod_t                    ex_q, ex_d, mem_q, mem_d;
    wb_rec_t                  wb_q, wb_d;
    logic [NUM_SRC*REG_W-1:0] ex_src_q, ex_src_d;
    logic [NUM_SRC-1:0]       ex_used_q, ex_used_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_SRC*2-1:0]     sel_raw;
    logic                     lu_hit;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_match
        hazard_fwd_match #(.REG_W(REG_W)) u_match (
            .src_i         (ex_src_q[k*REG_W +: REG_W]),
            .used_i        (ex_used_q[k]),
            .mem_valid_i   (mem_q.valid),
            .mem_wb_en_i   (mem_q.wb_en),
            .mem_is_load_i (mem_q.is_load),
            .mem_dest_i    (mem_q.dest),
            .wb_valid_i    (wb_q.valid),
            .wb_wb_en_i    (wb_q.wb_en),
            .wb_dest_i     (wb_q.dest),
            .sel_o         (sel_raw[k*2 +: 2])
        );
    end

    always_comb begin
        lu_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ex_q.valid && ex_q.wb_en && ex_q.is_load && id_src_used[k] &&
                (id_src[k*REG_W +: REG_W] != '0) && (id_src[k*REG_W +: REG_W] == ex_q.dest)) begin
                lu_hit = 1'b1;
            end
        end
        lu_hit = lu_hit && id_valid;
    end

    // Reset outranks every other event, so outputs are quiet while it is held.
    assign fwd_sel      = rst ? {NUM_SRC{FWD_RF}} : sel_raw;
    assign freeze       = !rst && mem_busy;
    assign stall_if_id  = !rst && (mem_busy || (!flush && lu_hit));
    assign bubble_ex    = !rst && !mem_busy && !flush && lu_hit;
    assign lu_stall_cnt = cnt_q;

    always_comb begin
        ex_d      = ex_q;
        ex_src_d  = ex_src_q;
        ex_used_d = ex_used_q;
        mem_d     = mem_q;
        wb_d      = wb_q;
        cnt_d     = cnt_q;
        if (!mem_busy) begin
            wb_d  = '{valid: mem_q.valid, wb_en: mem_q.wb_en, dest: mem_q.dest};
            mem_d = ex_q;
            if (flush || lu_hit) begin
                ex_d      = '0;
                ex_src_d  = '0;
                ex_used_d = '0;
            end else begin
                ex_d      = '{valid: id_valid, wb_en: id_wb_en, is_load: id_is_load, dest: id_dest};
                ex_src_d  = id_src;
                ex_used_d = id_src_used;
            end
            if (lu_hit && !flush && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            ex_src_q  <= '0;
            ex_used_q <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            cnt_q     <= '0;
        end else begin
            ex_q      <= ex_d;
            ex_src_q  <= ex_src_d;
            ex_used_q <= ex_used_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: instruction-level pipeline model checked every cycle,
// plus directed scenarios with literal expectations; a second instance uses CNT_W=2.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [14:0] id_src;
    logic [2:0]  id_src_used;
    logic [4:0]  id_dest;
    logic        id_wb_en;
    logic        id_is_load;
    logic        flush;
    logic        mem_busy;

    logic [5:0]  fwd_sel, fwd_sel_s;
    logic        stall_if_id, stall_s;
    logic        bubble_ex, bubble_s;
    logic        freeze, freeze_s;
    logic [15:0] lu_stall_cnt;
    logic [1:0]  lu_stall_cnt_s;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_is_load(id_is_load), .flush(flush),
        .mem_busy(mem_busy), .fwd_sel(fwd_sel), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
        .freeze(freeze), .lu_stall_cnt(lu_stall_cnt)
    );

    hazard_forward_unit #(.NUM_SRC(3), .REG_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_is_load(id_is_load), .flush(flush),
        .mem_busy(mem_busy), .fwd_sel(fwd_sel_s), .stall_if_id(stall_s), .bubble_ex(bubble_s),
        .freeze(freeze_s), .lu_stall_cnt(lu_stall_cnt_s)
    );

    // One instruction as the model sees it.
    typedef struct packed {
        bit            valid;
        bit            wb_en;
        bit            is_load;
        bit [4:0]      dest;
        bit [2:0][4:0] src;
        bit [2:0]      used;
    } instr_t;

    instr_t m_ex, m_mem, m_wb;
    int     m_cnt;
    bit     started = 1'b0;

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(instr_t r, bit [4:0] s);
        return r.valid && r.wb_en && (s != 0) && (r.dest == s);
    endfunction

    function automatic instr_t cur_id();
        instr_t r;
        r.valid   = id_valid;
        r.wb_en   = id_wb_en;
        r.is_load = id_is_load;
        r.dest    = id_dest;
        r.src     = id_src;
        r.used    = id_src_used;
        return r;
    endfunction

    // Newest finished result wins; a load sitting in MEM has nothing to give yet.
    function automatic bit [1:0] exp_sel(int k);
        if (!m_ex.used[k]) return 2'd0;
        if (writes(m_mem, m_ex.src[k]) && !m_mem.is_load) return 2'd1;
        if (writes(m_wb, m_ex.src[k])) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit exp_lu();
        bit hit = 1'b0;
        for (int k = 0; k < 3; k++)
            if (id_src_used[k] && m_ex.is_load && writes(m_ex, id_src[k*5 +: 5])) hit = 1'b1;
        return hit && id_valid;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ex <= '0; m_mem <= '0; m_wb <= '0; m_cnt <= 0; started <= 1'b1;
        end else if (!mem_busy) begin
            m_wb  <= m_mem;
            m_mem <= m_ex;
            if (flush || exp_lu()) m_ex <= '0;
            else                   m_ex <= cur_id();
            if (!flush && exp_lu()) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [5:0] e_fwd;
            bit e_stall, e_bub, e_frz;
            e_fwd   = rst ? 6'd0 : {exp_sel(2), exp_sel(1), exp_sel(0)};
            e_frz   = !rst && mem_busy;
            e_stall = !rst && (mem_busy || (!flush && exp_lu()));
            e_bub   = !rst && !mem_busy && !flush && exp_lu();
            chk("cyc_fwd_sel", fwd_sel, e_fwd);
            chk("cyc_stall", stall_if_id, e_stall);
            chk("cyc_bubble", bubble_ex, e_bub);
            chk("cyc_freeze", freeze, e_frz);
            chk("cyc_cnt", lu_stall_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
            chk("cyc_fwd_sel_sat", fwd_sel_s, e_fwd);
            chk("cyc_stall_sat", stall_s, e_stall);
            chk("cyc_bubble_sat", bubble_s, e_bub);
            chk("cyc_freeze_sat", freeze_s, e_frz);
            chk("cyc_cnt_sat", lu_stall_cnt_s, (m_cnt > 3) ? 3 : m_cnt);
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (m_ex.valid && m_ex.used[k] && writes(m_mem, m_ex.src[k]) && m_mem.is_load) begin
                    n_fail++;
                    $display("FAIL illegal_mem_load: operand %0d of EX matches a load in MEM (t=%0t)", k, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic id_in(bit v, bit [4:0] s0, bit [4:0] s1, bit [4:0] s2, bit [2:0] u,
                         bit [4:0] d, bit w, bit l);
        id_valid = v; id_src = {s2, s1, s0}; id_src_used = u;
        id_dest = d; id_wb_en = w; id_is_load = l;
    endtask

    task automatic nop();
        id_in(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_busy = 1'b0;
        id_in(1'b1, 5'd3, 5'd3, 5'd3, 3'b111, 5'd3, 1'b1, 1'b1);
        step(); step();
        chk("rst_fwd", fwd_sel, 0);
        chk("rst_stall", stall_if_id, 0);
        chk("rst_bubble", bubble_ex, 0);
        chk("rst_cnt", lu_stall_cnt, 0);
        nop(); rst = 1'b0;
        step();

        // ALU chain: adjacent, one apart, and MEM over WB
        id_in(1, 5'd1, 5'd2, 5'd0, 3'b011, 5'd3, 1, 0); step();
        id_in(1, 5'd3, 5'd4, 5'd0, 3'b011, 5'd6, 1, 0); step();
        chk("alu_mem_fwd", fwd_sel, 6'b000001);
        id_in(1, 5'd8, 5'd9, 5'd0, 3'b011, 5'd10, 1, 0); step();
        id_in(1, 5'd11, 5'd6, 5'd0, 3'b011, 5'd12, 1, 0); step();
        chk("alu_wb_fwd", fwd_sel, 6'b001000);
        id_in(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd12, 1, 0); step();
        id_in(1, 5'd12, 5'd0, 5'd12, 3'b101, 5'd13, 1, 0); step();
        chk("mem_over_wb", fwd_sel, 6'b010001);

        // r0 destination and unused operands
        id_in(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1, 1); step();
        id_in(1, 5'd0, 5'd0, 5'd0, 3'b111, 5'd14, 1, 0); #1;
        chk("r0_no_stall", stall_if_id, 0);
        step();
        chk("r0_no_fwd", fwd_sel, 0);
        id_in(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd15, 1, 1); step();
        id_in(1, 5'd15, 5'd15, 5'd15, 3'b000, 5'd16, 1, 0); #1;
        chk("unused_no_stall", stall_if_id, 0);
        chk("unused_no_bubble", bubble_ex, 0);
        step();
        chk("unused_no_fwd", fwd_sel, 0);

        // Load-use: one stall cycle, then WB bypass
        id_in(1, 5'd1, 5'd0, 5'd0, 3'b001, 5'd5, 1, 1); step();
        id_in(1, 5'd2, 5'd5, 5'd0, 3'b011, 5'd17, 1, 0); #1;
        chk("lu_stall", stall_if_id, 1);
        chk("lu_bubble", bubble_ex, 1);
        chk("lu_no_freeze", freeze, 0);
        step();
        chk("lu_stall_gone", stall_if_id, 0);
        chk("lu_bubble_gone", bubble_ex, 0);
        chk("lu_cnt1", lu_stall_cnt, 1);
        step();
        chk("lu_wb_fwd", fwd_sel, 6'b001000);

        // Freeze during a pending load-use stall
        id_in(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd7, 1, 1); step();
        id_in(1, 5'd0, 5'd0, 5'd7, 3'b100, 5'd18, 1, 0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_freeze", freeze, 1);
            chk("frz_stall", stall_if_id, 1);
            chk("frz_no_bubble", bubble_ex, 0);
            step();
        end
        mem_busy = 1'b0; #1;
        chk("frz_cnt_held", lu_stall_cnt, 1);
        chk("frz_hazard_kept", bubble_ex, 1);
        step();
        chk("frz_cnt2", lu_stall_cnt, 2);
        chk("frz_stall_done", stall_if_id, 0);
        step();
        chk("frz_wb_fwd", fwd_sel, 6'b100000);

        // Flush outranks load-use
        id_in(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd9, 1, 1); step();
        id_in(1, 5'd9, 5'd0, 5'd0, 3'b001, 5'd19, 1, 0);
        flush = 1'b1; #1;
        chk("flush_no_stall", stall_if_id, 0);
        chk("flush_no_bubble", bubble_ex, 0);
        step();
        flush = 1'b0; nop();
        chk("flush_cnt", lu_stall_cnt, 2);
        step();

        // Saturation of the 2-bit counter
        for (int i = 0; i < 4; i++) begin
            id_in(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'(20 + i), 1, 1); step();
            id_in(1, 5'(20 + i), 5'd0, 5'd0, 3'b001, 5'd24, 1, 0); step();
            nop(); step();
        end
        chk("cnt16_six", lu_stall_cnt, 6);
        chk("cnt2_sat", lu_stall_cnt_s, 3);

        // Reset in the middle of a hazard
        id_in(1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd7, 1, 1); step();
        id_in(1, 5'd7, 5'd0, 5'd0, 3'b001, 5'd25, 1, 0); #1;
        chk("mid_hazard", stall_if_id, 1);
        rst = 1'b1; #1;
        chk("mid_rst_quiet", stall_if_id, 0);
        step();
        rst = 1'b0; #1;
        chk("mid_rst_dropped", stall_if_id, 0);
        chk("mid_rst_cnt", lu_stall_cnt, 0);
        nop();
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
